// File: rtl/tmds_channel_decoder.sv
// tmds_channel_decoder
//   One TMDS receive lane: word alignment by control-token runs, symbol
//   classification and 8b/10b data decode, in the pixel clock domain.
//   Optional lock-loss counter: define TMDS_DECODER_ERRCNT_EN to add the
//   err_count port and its saturating counter.
//
//   Pipeline: raw_in/raw_prev -> sym (comb, selected by offset)
//             -> stage 1 (sym_q + token class) -> stage 2 (D/C0/C1/DE).
//   The alignment FSM runs on the stage-1 class, so `locked` and the first
//   live stage-2 outputs change on the same edge.
//
//   The FSM state is visible directly on `locked` (1 = LOCKED, 0 = SEARCH).
module tmds_channel_decoder #(
  parameter int CTRL_RUN       = 8,
  parameter int SEARCH_TIMEOUT = 2048,
  parameter int LOCK_TIMEOUT   = 4096
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] raw_in,
  output logic [7:0] D,
  output logic       C0,
  output logic       C1,
  output logic       DE,
  output logic       locked,
  output logic [3:0] offset
`ifdef TMDS_DECODER_ERRCNT_EN
  ,
  output logic [15:0] err_count
`endif
);

  localparam int RUN_W   = $clog2(CTRL_RUN + 1);
  localparam int DWELL_W = $clog2(SEARCH_TIMEOUT);
  localparam int SIL_W   = $clog2(LOCK_TIMEOUT + 1);

  localparam logic [RUN_W-1:0]   RUN_DONE   = RUN_W'(CTRL_RUN);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SEARCH_TIMEOUT - 1);
  localparam logic [SIL_W-1:0]   SIL_DONE   = SIL_W'(LOCK_TIMEOUT);

  localparam logic [9:0] TOK_00 = 10'b1101010100;
  localparam logic [9:0] TOK_01 = 10'b0010101011;
  localparam logic [9:0] TOK_10 = 10'b0101010100;
  localparam logic [9:0] TOK_11 = 10'b1010101011;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t             state;
  state_t             state_next;

  logic [9:0]         raw_prev;
  logic [18:0]        window;
  logic [9:0]         sym;
  logic               sym_tok;
  logic [1:0]         sym_c;

  logic [9:0]         sym_q;
  logic               tok_q;
  logic [1:0]         tok_c_q;
  logic [1:0]         c_last;

  logic [7:0]         tdata;
  logic [7:0]         data_dec;

  logic [3:0]         offset_next;
  logic [3:0]         offset_adv;
  logic [RUN_W-1:0]   run;
  logic [RUN_W-1:0]   run_next;
  logic [RUN_W-1:0]   run_cand;
  logic [DWELL_W-1:0] dwell;
  logic [DWELL_W-1:0] dwell_next;
  logic [SIL_W-1:0]   silence;
  logic [SIL_W-1:0]   silence_next;
  logic [SIL_W-1:0]   silence_cand;

  // Bit 9 of raw_in can never start a symbol for offsets 0..9, so it is
  // kept only in raw_prev.
  assign window     = {raw_in[8:0], raw_prev};
  assign offset_adv = (offset == 4'd9) ? 4'd0 : offset + 4'd1;
  assign locked     = (state == LOCKED);

  // Previous deserialized word, needed to form the 20-bit alignment window.
  always_ff @(posedge clk) begin
    if (!reset) begin
      raw_prev <= '0;
    end else begin
      raw_prev <= raw_in;
    end
  end

  // Barrel select of the candidate symbol at the current bit offset.
  always_comb begin
    sym = window[9:0];
    case (offset)
      4'd0:    sym = window[9:0];
      4'd1:    sym = window[10:1];
      4'd2:    sym = window[11:2];
      4'd3:    sym = window[12:3];
      4'd4:    sym = window[13:4];
      4'd5:    sym = window[14:5];
      4'd6:    sym = window[15:6];
      4'd7:    sym = window[16:7];
      4'd8:    sym = window[17:8];
      4'd9:    sym = window[18:9];
      default: sym = window[9:0];
    endcase
  end

  // Control-token classification; sym_c is {C1, C0}.
  always_comb begin
    sym_tok = 1'b0;
    sym_c   = 2'b00;
    case (sym)
      TOK_00: begin sym_tok = 1'b1; sym_c = 2'b00; end
      TOK_01: begin sym_tok = 1'b1; sym_c = 2'b01; end
      TOK_10: begin sym_tok = 1'b1; sym_c = 2'b10; end
      TOK_11: begin sym_tok = 1'b1; sym_c = 2'b11; end
      default: begin sym_tok = 1'b0; sym_c = 2'b00; end
    endcase
  end

  // Stage 1: register the symbol together with its class.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sym_q   <= '0;
      tok_q   <= 1'b0;
      tok_c_q <= 2'b00;
    end else begin
      sym_q   <= sym;
      tok_q   <= sym_tok;
      tok_c_q <= sym_c;
    end
  end

  // Data decode of the stage-1 symbol: undo optional inversion, then the
  // XOR/XNOR transition chain selected by bit 8.
  always_comb begin
    tdata       = sym_q[9] ? ~sym_q[7:0] : sym_q[7:0];
    data_dec    = '0;
    data_dec[0] = tdata[0];
    for (int i = 1; i < 8; i++) begin
      data_dec[i] = sym_q[8] ? (tdata[i] ^ tdata[i-1]) : ~(tdata[i] ^ tdata[i-1]);
    end
  end

  // Alignment FSM next-state: token-run search with per-offset dwell
  // timeout, and silence watchdog while locked.
  always_comb begin
    state_next   = state;
    offset_next  = offset;
    run_next     = run;
    dwell_next   = dwell;
    silence_next = silence;
    run_cand     = '0;
    silence_cand = '0;
    case (state)
      SEARCH: begin
        silence_next = '0;
        if (tok_q) begin
          run_cand = ((run != '0) && (tok_c_q == c_last)) ? run + RUN_W'(1) : RUN_W'(1);
        end
        if (run_cand == RUN_DONE) begin
          // A completed run takes priority over a coincident timeout.
          state_next = LOCKED;
          run_next   = '0;
          dwell_next = '0;
        end else if (dwell == DWELL_LAST) begin
          offset_next = offset_adv;
          dwell_next  = '0;
          run_next    = '0;
        end else begin
          dwell_next = dwell + DWELL_W'(1);
          run_next   = run_cand;
        end
      end
      LOCKED: begin
        run_next     = '0;
        dwell_next   = '0;
        silence_cand = tok_q ? '0 : silence + SIL_W'(1);
        if (silence_cand == SIL_DONE) begin
          state_next   = SEARCH;
          offset_next  = offset_adv;
          silence_next = '0;
        end else begin
          silence_next = silence_cand;
        end
      end
      default: begin
        state_next   = SEARCH;
        offset_next  = '0;
        run_next     = '0;
        dwell_next   = '0;
        silence_next = '0;
      end
    endcase
  end

  // Alignment FSM state, offset and counter registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= SEARCH;
      offset  <= '0;
      run     <= '0;
      dwell   <= '0;
      silence <= '0;
    end else begin
      state   <= state_next;
      offset  <= offset_next;
      run     <= run_next;
      dwell   <= dwell_next;
      silence <= silence_next;
    end
  end

  // Stage 2: decoded outputs, forced to zero whenever the lane is not
  // locked after this edge; c_last remembers the most recent token.
  always_ff @(posedge clk) begin
    if (!reset) begin
      D      <= '0;
      C0     <= 1'b0;
      C1     <= 1'b0;
      DE     <= 1'b0;
      c_last <= 2'b00;
    end else begin
      if (tok_q) begin
        c_last <= tok_c_q;
      end
      if (state_next == LOCKED) begin
        if (tok_q) begin
          D  <= '0;
          DE <= 1'b0;
          C1 <= tok_c_q[1];
          C0 <= tok_c_q[0];
        end else begin
          D  <= data_dec;
          DE <= 1'b1;
          C1 <= c_last[1];
          C0 <= c_last[0];
        end
      end else begin
        D  <= '0;
        DE <= 1'b0;
        C1 <= 1'b0;
        C0 <= 1'b0;
      end
    end
  end

`ifdef TMDS_DECODER_ERRCNT_EN
  logic lock_drop;
  assign lock_drop = (state == LOCKED) && (state_next == SEARCH);

  // Saturating count of LOCKED -> SEARCH transitions.
  always_ff @(posedge clk) begin
    if (!reset) begin
      err_count <= '0;
    end else if (lock_drop && (err_count != 16'hFFFF)) begin
      err_count <= err_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// tb_tmds_channel_decoder
//   Drives aligned, rotated and random TMDS word streams into the decoder
//   and compares every cycle against a bit-stream level model of the lane.
//   Build with TMDS_DECODER_ERRCNT_EN defined to also cover err_count.
module tb_tmds_channel_decoder;

  localparam int CTRL_RUN       = 8;
  localparam int SEARCH_TIMEOUT = 2048;
  localparam int LOCK_TIMEOUT   = 4096;

  localparam logic [9:0] T00 = 10'b1101010100;
  localparam logic [9:0] T01 = 10'b0010101011;
  localparam logic [9:0] T10 = 10'b0101010100;
  localparam logic [9:0] T11 = 10'b1010101011;

  logic       clk;
  logic       reset;
  logic [9:0] raw_in;
  logic [7:0] D;
  logic       C0;
  logic       C1;
  logic       DE;
  logic       locked;
  logic [3:0] offset;
`ifdef TMDS_DECODER_ERRCNT_EN
  logic [15:0] err_count;
`endif

  int n_checks;
  int n_fail;

  // Model state: bit-stream view of the lane.
  logic [9:0] tok_tab [4];
  logic [9:0] m_prev;
  logic [9:0] m_s1;
  logic [1:0] m_clast;
  int         m_off;
  logic       m_locked;
  int         m_run;
  int         m_dwell;
  int         m_sil;
  int         m_err;
  logic [7:0] m_D;
  logic [1:0] m_C;
  logic       m_DE;

  tmds_channel_decoder #(
    .CTRL_RUN(CTRL_RUN),
    .SEARCH_TIMEOUT(SEARCH_TIMEOUT),
    .LOCK_TIMEOUT(LOCK_TIMEOUT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .raw_in(raw_in),
    .D(D),
    .C0(C0),
    .C1(C1),
    .DE(DE),
    .locked(locked),
    .offset(offset)
`ifdef TMDS_DECODER_ERRCNT_EN
    ,
    .err_count(err_count)
`endif
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Token lookup: index of the table entry is the {C1,C0} value.
  function automatic void classify(input logic [9:0] s, output logic is_tok, output logic [1:0] c);
    is_tok = 1'b0;
    c      = 2'b00;
    for (int k = 0; k < 4; k++) begin
      if (s == tok_tab[k]) begin
        is_tok = 1'b1;
        c      = 2'(k);
      end
    end
  endfunction

  // Data decode as a whole-byte expression.
  function automatic logic [7:0] mdec(input logic [9:0] s);
    logic [7:0] t;
    t = s[9] ? ~s[7:0] : s[7:0];
    return t ^ {t[6:0], 1'b0} ^ (s[8] ? 8'h00 : 8'hFE);
  endfunction

  function automatic logic [9:0] rand_data();
    logic [9:0] w;
    logic       tk;
    logic [1:0] c;
    do begin
      w = 10'($urandom_range(0, 1023));
      classify(w, tk, c);
    end while (tk);
    return w;
  endfunction

  // One clock of the lane model, applied with the inputs seen at the edge.
  task automatic model_step();
    logic [19:0] win;
    logic [9:0]  sym;
    logic        s1_tok;
    logic [1:0]  s1_c;
    int          run_c;
    int          sil_c;
    logic        nl;
    int          noff;
    if (!reset) begin
      m_prev = '0; m_s1 = '0; m_clast = '0; m_off = 0; m_locked = 1'b0;
      m_run = 0; m_dwell = 0; m_sil = 0; m_err = 0;
      m_D = '0; m_C = '0; m_DE = 1'b0;
      return;
    end
    win = {raw_in, m_prev};
    sym = 10'(win >> m_off);
    classify(m_s1, s1_tok, s1_c);
    nl   = m_locked;
    noff = m_off;
    if (!m_locked) begin
      run_c = s1_tok ? ((m_run != 0 && s1_c == m_clast) ? m_run + 1 : 1) : 0;
      if (run_c == CTRL_RUN) begin
        nl = 1'b1; m_run = 0; m_dwell = 0; m_sil = 0;
      end else if (m_dwell == SEARCH_TIMEOUT - 1) begin
        noff = (m_off + 1) % 10; m_dwell = 0; m_run = 0;
      end else begin
        m_dwell++; m_run = run_c;
      end
    end else begin
      sil_c = s1_tok ? 0 : m_sil + 1;
      if (sil_c == LOCK_TIMEOUT) begin
        nl = 1'b0; noff = (m_off + 1) % 10; m_sil = 0; m_run = 0; m_dwell = 0;
        if (m_err < 65535) m_err++;
      end else begin
        m_sil = sil_c;
      end
    end
    if (nl && s1_tok) begin
      m_D = '0; m_DE = 1'b0; m_C = s1_c;
    end else if (nl) begin
      m_D = mdec(m_s1); m_DE = 1'b1; m_C = m_clast;
    end else begin
      m_D = '0; m_DE = 1'b0; m_C = '0;
    end
    if (s1_tok) m_clast = s1_c;
    m_s1     = sym;
    m_prev   = raw_in;
    m_locked = nl;
    m_off    = noff;
  endtask

  // Per-cycle comparison of every output against the model.
  task automatic compare_outputs();
    check("D", int'(D), int'(m_D));
    check("DE", int'(DE), int'(m_DE));
    check("C1C0", int'({C1, C0}), int'(m_C));
    check("locked", int'(locked), int'(m_locked));
    check("offset", int'(offset), m_off);
`ifdef TMDS_DECODER_ERRCNT_EN
    check("err_count", int'(err_count), m_err);
`endif
  endtask

  // Driver: apply a word, clock it, advance the model, compare on negedge.
  task automatic step(input logic [9:0] w);
    raw_in = w;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) step(10'd0);
    check("rst_locked", int'(locked), 0);
    check("rst_offset", int'(offset), 0);
    check("rst_D", int'(D), 0);
    check("rst_DE", int'(DE), 0);
    check("rst_C", int'({C1, C0}), 0);
    reset = 1'b1;
  endtask

  // 16 aligned T00 tokens; lock must appear on the 10th word edge.
  task automatic aligned_lock(input string tag);
    int first_lock;
    first_lock = -1;
    for (int i = 1; i <= 16; i++) begin
      step(T00);
      if (locked && first_lock < 0) first_lock = i;
    end
    check({tag, "_lock_latency"}, first_lock, 10);
    check({tag, "_offset"}, int'(offset), 0);
    check({tag, "_C"}, int'({C1, C0}), 0);
    check({tag, "_DE"}, int'(DE), 0);
    check({tag, "_model_locked"}, int'(m_locked), 1);
  endtask

  initial begin
    logic [9:0] seq [8];
    logic [9:0] rot;
    int         steps;
    logic       seen;

    tok_tab[0] = T00; tok_tab[1] = T01; tok_tab[2] = T10; tok_tab[3] = T11;
    n_checks = 0;
    n_fail   = 0;
    raw_in   = '0;
    reset    = 1'b0;

    // Aligned stream at offset 0.
    do_reset();
    aligned_lock("t1");
    for (int i = 0; i < 20; i++) step(rand_data());

    // Hand-decoded data symbols.
    step(10'b0100000000);
    step(10'b1011111111);
    step(rand_data());
    check("dec_0100000000_D", int'(D), 8'h00);
    check("dec_0100000000_DE", int'(DE), 1);
    step(rand_data());
    check("dec_1011111111_D", int'(D), 8'hFE);
    check("dec_1011111111_DE", int'(DE), 1);

    // Token sequence 00,01,10,11 then data holding the last C value.
    seq = '{T00, T01, T10, T11, rand_data(), rand_data(), rand_data(), rand_data()};
    for (int k = 0; k < 8; k++) begin
      step(seq[k]);
      if (k >= 2 && k - 2 < 4) begin
        check("tokseq_C", int'({C1, C0}), k - 2);
        check("tokseq_DE", int'(DE), 0);
      end else if (k >= 6) begin
        check("tokhold_C", int'({C1, C0}), 3);
        check("tokhold_DE", int'(DE), 1);
      end
    end

    // Mixed random traffic while locked.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 7) == 0) step(tok_tab[$urandom_range(0, 3)]);
      else step(rand_data());
    end

    // Data only: silence watchdog must drop lock and slip one bit.
    seen  = 1'b0;
    steps = 0;
    while (!seen && steps < LOCK_TIMEOUT + 200) begin
      step(rand_data());
      steps++;
      if (!locked) seen = 1'b1;
    end
    check("silence_drop", int'(seen), 1);
    check("silence_offset", int'(offset), 1);
    check("silence_model_offset", m_off, 1);
`ifdef TMDS_DECODER_ERRCNT_EN
    check("silence_err_count", int'(err_count), 1);
`endif
    for (int i = 0; i < 20; i++) step(rand_data());

    // Stream rotated by 7 bits: search walks offsets 0..7 and locks at 7.
    do_reset();
    rot   = {T00[2:0], T00[9:3]};
    seen  = 1'b0;
    steps = 0;
    while (!seen && steps < 8 * SEARCH_TIMEOUT + 100) begin
      step(rot);
      steps++;
      if (locked) seen = 1'b1;
    end
    check("rot_lock_seen", int'(seen), 1);
    check("rot_offset", int'(offset), 7);
    check("rot_model_offset", m_off, 7);
    check("rot_search_long", int'(steps > 7 * SEARCH_TIMEOUT), 1);
    for (int i = 0; i < 10; i++) step(rot);

    // Reset while locked, then relock from scratch.
    reset = 1'b0;
    step(rot);
    check("midrst_locked", int'(locked), 0);
    check("midrst_offset", int'(offset), 0);
    check("midrst_D", int'(D), 0);
    check("midrst_DE", int'(DE), 0);
    check("midrst_C", int'({C1, C0}), 0);
    reset = 1'b1;
    aligned_lock("t6");
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 5) == 0) step(tok_tab[$urandom_range(0, 3)]);
      else step(rand_data());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
